// File: rtl/program_loader.sv
// program_loader: turns a framed serial byte stream into sequential 32-bit writes on the
// instruction memory programming port and reports done/error per frame.
// Optional readback check of the loaded words when PROGRAM_LOADER_VERIFY_EN is defined.
module program_loader #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    input  logic             abort,
    output logic             prg_mode,
    output logic             prg_we,
    output logic [31:0]      prg_addr,
    output logic [31:0]      prg_wd,
    input  logic [31:0]      prg_rd,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] words_loaded
);

    localparam logic [7:0] SyncByte = 8'hA5;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StCnt,
        StData,
        StCsum,
`ifdef PROGRAM_LOADER_VERIFY_EN
        StVerify,
`endif
        StFinish
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       byte_cnt_q, byte_cnt_d;
    logic [31:0]      addr_q, addr_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [31:0]      word_q, word_d;
    logic [7:0]       sum_q, sum_d;
    logic [CNT_W-1:0] wl_q, wl_d;
    logic             we_q, we_d;
    logic [31:0]      waddr_q, waddr_d;
    logic [31:0]      wd_q, wd_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic             mode_q;

`ifdef PROGRAM_LOADER_VERIFY_EN
    logic [31:0] start_q, start_d;
    logic [15:0] vidx_q, vidx_d;
    logic        vphase_q, vphase_d;
    logic        vdone_q, vdone_d;
    logic [7:0]  vsum_q, vsum_d;
`else
    logic unused_prg_rd;
    assign unused_prg_rd = ^prg_rd;
`endif

    // Next-state: frame parsing, write generation and optional readback.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        word_d     = word_q;
        sum_d      = sum_q;
        wl_d       = wl_q;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wd_d       = wd_q;
        done_d     = done_q;
        error_d    = error_q;
`ifdef PROGRAM_LOADER_VERIFY_EN
        start_d    = start_q;
        vidx_d     = vidx_q;
        vphase_d   = vphase_q;
        vdone_d    = vdone_q;
        vsum_d     = vsum_q;
`endif
        // Address and word count advance in the cycle after the write strobe.
        if (we_q) begin
            addr_d = addr_q + 32'd4;
            wl_d   = wl_q + CNT_W'(1);
        end

        if (abort) begin
            // Abort drops any byte offered in the same cycle.
            if (state_q != StIdle) begin
                state_d = StIdle;
                error_d = 1'b1;
                done_d  = 1'b0;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (rx_valid && rx_data == SyncByte) begin
                        state_d    = StAddr;
                        done_d     = 1'b0;
                        error_d    = 1'b0;
                        wl_d       = '0;
                        byte_cnt_d = 2'd0;
                        sum_d      = 8'd0;
                        word_d     = 32'd0;
                    end
                end
                StAddr: begin
                    if (rx_valid) begin
                        addr_d     = {addr_q[23:0], rx_data};
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            addr_d[1:0] = 2'b00;
`ifdef PROGRAM_LOADER_VERIFY_EN
                            start_d     = addr_d;
`endif
                            state_d     = StCnt;
                        end
                    end
                end
                StCnt: begin
                    if (rx_valid) begin
                        cnt_d = {cnt_q[7:0], rx_data};
                        if (byte_cnt_q == 2'd1) begin
                            byte_cnt_d = 2'd0;
                            state_d    = (cnt_d == 16'd0) ? StCsum : StData;
                        end else begin
                            byte_cnt_d = 2'd1;
                        end
                    end
                end
                StData: begin
                    if (rx_valid) begin
                        word_d     = {word_q[23:0], rx_data};
                        sum_d      = sum_q + rx_data;
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            we_d    = 1'b1;
                            waddr_d = addr_q;
                            wd_d    = word_d;
                            // wl_q is settled here: consecutive words are >= 4 cycles apart.
                            if (32'(wl_q) + 32'd1 == 32'(cnt_q)) begin
                                state_d = StCsum;
                            end
                        end
                    end
                end
                StCsum: begin
                    if (rx_valid) begin
                        if (rx_data == sum_q) begin
`ifdef PROGRAM_LOADER_VERIFY_EN
                            state_d  = StVerify;
                            waddr_d  = start_q;
                            vidx_d   = 16'd0;
                            vphase_d = 1'b0;
                            vsum_d   = 8'd0;
                            vdone_d  = (cnt_q == 16'd0);
`else
                            state_d  = StFinish;
                            done_d   = 1'b1;
`endif
                        end else begin
                            state_d = StFinish;
                            error_d = 1'b1;
                        end
                    end
                end
`ifdef PROGRAM_LOADER_VERIFY_EN
                StVerify: begin
                    // Phase 0: address on the bus; phase 1: read data valid, sum it.
                    if (vdone_q) begin
                        state_d = StFinish;
                        if (vsum_q == sum_q) begin
                            done_d = 1'b1;
                        end else begin
                            error_d = 1'b1;
                        end
                    end else if (!vphase_q) begin
                        vphase_d = 1'b1;
                    end else begin
                        vphase_d = 1'b0;
                        vsum_d   = vsum_q + prg_rd[31:24] + prg_rd[23:16]
                                 + prg_rd[15:8] + prg_rd[7:0];
                        if (vidx_q + 16'd1 == cnt_q) begin
                            vdone_d = 1'b1;
                        end else begin
                            vidx_d  = vidx_q + 16'd1;
                            waddr_d = waddr_q + 32'd4;
                        end
                    end
                end
`endif
                StFinish: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // State and registered outputs, synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            byte_cnt_q <= 2'd0;
            addr_q     <= 32'd0;
            cnt_q      <= 16'd0;
            word_q     <= 32'd0;
            sum_q      <= 8'd0;
            wl_q       <= '0;
            we_q       <= 1'b0;
            waddr_q    <= 32'd0;
            wd_q       <= 32'd0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            mode_q     <= 1'b0;
`ifdef PROGRAM_LOADER_VERIFY_EN
            start_q    <= 32'd0;
            vidx_q     <= 16'd0;
            vphase_q   <= 1'b0;
            vdone_q    <= 1'b0;
            vsum_q     <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            word_q     <= word_d;
            sum_q      <= sum_d;
            wl_q       <= wl_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wd_q       <= wd_d;
            done_q     <= done_d;
            error_q    <= error_d;
            mode_q     <= (state_d != StIdle);
`ifdef PROGRAM_LOADER_VERIFY_EN
            start_q    <= start_d;
            vidx_q     <= vidx_d;
            vphase_q   <= vphase_d;
            vdone_q    <= vdone_d;
            vsum_q     <= vsum_d;
`endif
        end
    end

    assign prg_mode     = mode_q;
    assign busy         = mode_q;
    assign prg_we       = we_q;
    assign prg_addr     = waddr_q;
    assign prg_wd       = wd_q;
    assign done         = done_q;
    assign error        = error_q;
    assign words_loaded = wl_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: per-cycle vector table for one full frame, then hand-written
// sequences for checksum failure, address alignment/wrap, abort, reset and readback verify.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        abort = 1'b0;
    logic        prg_mode, prg_we, busy, done, error;
    logic [31:0] prg_addr, prg_wd;
    logic [31:0] prg_rd = 32'd0;
    logic [15:0] words_loaded;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    program_loader #(.CNT_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .abort        (abort),
        .prg_mode     (prg_mode),
        .prg_we       (prg_we),
        .prg_addr     (prg_addr),
        .prg_wd       (prg_wd),
        .prg_rd       (prg_rd),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    // Instruction RAM model: 16 words, read data one cycle after the address.
    logic [31:0] ram [16];
    logic        corrupt = 1'b0;
    always @(posedge clk) begin
        if (prg_we) ram[prg_addr[5:2]] <= prg_wd;
        prg_rd <= ram[prg_addr[5:2]]
                  ^ ((corrupt && prg_addr[5:2] == 4'd1) ? 32'h0000_0100 : 32'h0);
    end

    // Log of every write strobe as {addr, data}.
    logic [63:0] wlog [$];
    always @(negedge clk) if (prg_we) wlog.push_back({prg_addr, prg_wd});

    typedef struct {
        logic        rv;
        logic [7:0]  d;
        logic        mode;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        dn;
        logic        er;
        logic [15:0] wl;
    } vec_t;
    vec_t vecs [$];

    task automatic add(input logic rv, input logic [7:0] d, input logic mode, input logic we,
                       input logic [31:0] addr, input logic [31:0] wd, input logic dn,
                       input logic er, input logic [15:0] wl);
        vec_t v;
        v.rv = rv; v.d = d; v.mode = mode; v.we = we; v.addr = addr; v.wd = wd;
        v.dn = dn; v.er = er; v.wl = wl;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic rv, input logic [7:0] d, input logic ab);
        rx_valid = rv;
        rx_data  = d;
        abort    = ab;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        abort    = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        cyc(1'b1, b, 1'b0);
    endtask

    task automatic send_hdr(input logic [31:0] addr, input logic [15:0] n);
        send(8'hA5);
        send(addr[31:24]); send(addr[23:16]); send(addr[15:8]); send(addr[7:0]);
        send(n[15:8]); send(n[7:0]);
    endtask

    task automatic send_word(input logic [31:0] w);
        send(w[31:24]); send(w[23:16]); send(w[15:8]); send(w[7:0]);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 64; i++) begin
            if (!prg_mode) break;
            cyc(1'b0, 8'h00, 1'b0);
        end
        chk(name, prg_mode, 1'b0);
    endtask

    task automatic all_zero(input string name);
        chk(name, {prg_mode, busy, prg_we, prg_addr, prg_wd, done, error, words_loaded}, 96'd0);
    endtask

    initial begin
        // Reset state.
        cyc(1'b0, 8'h00, 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        all_zero("reset_state");
        reset = 1'b0;

        // Idle bytes, then frame at 0x40 with two words; checksum of the data bytes is 0x42.
        //  rv    d     mode we addr          wd             dn er wl
        add(1'b1, 8'h00, 0, 0, 32'h0,         32'h0,         0, 0, 0);
        add(1'b1, 8'h12, 0, 0, 32'h0,         32'h0,         0, 0, 0);
        add(1'b1, 8'hA5, 1, 0, 32'h0,         32'h0,         0, 0, 0);
        add(1'b1, 8'h00, 1, 0, 32'h0,         32'h0,         0, 0, 0);
        add(1'b1, 8'h00, 1, 0, 32'h0,         32'h0,         0, 0, 0);
        add(1'b1, 8'h00, 1, 0, 32'h0,         32'h0,         0, 0, 0);
        add(1'b1, 8'h40, 1, 0, 32'h0,         32'h0,         0, 0, 0);
        add(1'b1, 8'h00, 1, 0, 32'h0,         32'h0,         0, 0, 0);
        add(1'b1, 8'h02, 1, 0, 32'h0,         32'h0,         0, 0, 0);
        add(1'b1, 8'hDE, 1, 0, 32'h0,         32'h0,         0, 0, 0);
        add(1'b1, 8'hAD, 1, 0, 32'h0,         32'h0,         0, 0, 0);
        add(1'b1, 8'hBE, 1, 0, 32'h0,         32'h0,         0, 0, 0);
        add(1'b1, 8'hEF, 1, 1, 32'h40,        32'hDEADBEEF,  0, 0, 0);
        add(1'b1, 8'h01, 1, 0, 32'h40,        32'hDEADBEEF,  0, 0, 1);
        add(1'b0, 8'h00, 1, 0, 32'h40,        32'hDEADBEEF,  0, 0, 1);
        add(1'b1, 8'h02, 1, 0, 32'h40,        32'hDEADBEEF,  0, 0, 1);
        add(1'b1, 8'h03, 1, 0, 32'h40,        32'hDEADBEEF,  0, 0, 1);
        add(1'b1, 8'h04, 1, 1, 32'h44,        32'h01020304,  0, 0, 1);
        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].rv, vecs[i].d, 1'b0);
            chk($sformatf("row%0d", i),
                {prg_mode, prg_we, prg_addr, prg_wd, done, error, words_loaded},
                {vecs[i].mode, vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].dn, vecs[i].er,
                 vecs[i].wl});
        end
        send(8'h42);
`ifdef PROGRAM_LOADER_VERIFY_EN
        chk("verify_enter", {prg_mode, done, error, words_loaded}, {1'b1, 1'b0, 1'b0, 16'd2});
        repeat (4) cyc(1'b0, 8'h00, 1'b0);
        chk("verify_busy", {prg_mode, done, error}, {1'b1, 1'b0, 1'b0});
        cyc(1'b0, 8'h00, 1'b0);
`endif
        chk("csum_done", {prg_mode, done, error, words_loaded}, {1'b1, 1'b1, 1'b0, 16'd2});
        cyc(1'b0, 8'h00, 1'b0);
        chk("mode_fall", {prg_mode, busy, done}, {1'b0, 1'b0, 1'b1});

        // Bad checksum: both writes still happen, error set.
        wlog.delete();
        send_hdr(32'h40, 16'd2);
        send_word(32'hDEADBEEF);
        send_word(32'h01020304);
        send(8'h43);
        chk("bad_csum", {done, error, words_loaded}, {1'b0, 1'b1, 16'd2});
        wait_idle("bad_csum_idle");
        chk("bad_csum_nwr", wlog.size(), 2);
        chk("bad_csum_wr0", wlog[0], {32'h40, 32'hDEADBEEF});
        chk("bad_csum_wr1", wlog[1], {32'h44, 32'h01020304});

        // Unaligned start address is forced down to a word boundary.
        wlog.delete();
        send_hdr(32'h43, 16'd1);
        send_word(32'h11223344);
        send(8'hAA);
        wait_idle("align_idle");
        chk("align_res", {done, error, words_loaded}, {1'b1, 1'b0, 16'd1});
        chk("align_wr", wlog[0], {32'h40, 32'h11223344});

        // Address wraps from 0xFFFFFFFC to 0.
        wlog.delete();
        send_hdr(32'hFFFFFFFC, 16'd2);
        send_word(32'hA0A0A0A0);
        send_word(32'h05050505);
        send(8'h94);
        wait_idle("wrap_idle");
        chk("wrap_res", {done, error, words_loaded}, {1'b1, 1'b0, 16'd2});
        chk("wrap_wr0", wlog[0], {32'hFFFFFFFC, 32'hA0A0A0A0});
        chk("wrap_wr1", wlog[1], {32'h00000000, 32'h05050505});

        // Abort mid-word, then a fresh frame clears error.
        wlog.delete();
        send_hdr(32'h40, 16'd2);
        send(8'hDE);
        send(8'hAD);
        cyc(1'b0, 8'h00, 1'b1);
        chk("abort", {prg_mode, prg_we, done, error}, {1'b0, 1'b0, 1'b0, 1'b1});
        repeat (3) cyc(1'b0, 8'h00, 1'b0);
        chk("abort_nwr", wlog.size(), 0);
        send(8'hA5);
        chk("resync", {prg_mode, done, error}, {1'b1, 1'b0, 1'b0});
        send(8'h00); send(8'h00); send(8'h00); send(8'h40); send(8'h00); send(8'h01);
        send_word(32'h11223344);
        send(8'hAA);
        wait_idle("resync_idle");
        chk("resync_res", {done, error, wlog.size()}, {1'b1, 1'b0, 32'd1});

        // Abort together with the 4th data byte drops the byte: no write.
        wlog.delete();
        send_hdr(32'h40, 16'd1);
        send(8'h11); send(8'h22); send(8'h33);
        cyc(1'b1, 8'h44, 1'b1);
        chk("abort_rx", {prg_mode, prg_we, error}, {1'b0, 1'b0, 1'b1});
        repeat (2) cyc(1'b0, 8'h00, 1'b0);
        chk("abort_rx_nwr", wlog.size(), 0);

        // Reset together with the 4th data byte: reset values, no write.
        send_hdr(32'h40, 16'd1);
        send(8'h11); send(8'h22); send(8'h33);
        reset = 1'b1;
        cyc(1'b1, 8'h44, 1'b0);
        reset = 1'b0;
        all_zero("reset_mid");
        cyc(1'b0, 8'h00, 1'b0);
        chk("reset_mid_nwr", wlog.size(), 0);

`ifdef PROGRAM_LOADER_VERIFY_EN
        // Corrupted readback of word 1 fails verify after 2N+1 cycles.
        corrupt = 1'b1;
        send_hdr(32'h40, 16'd2);
        send_word(32'hDEADBEEF);
        send_word(32'h01020304);
        send(8'h42);
        repeat (4) cyc(1'b0, 8'h00, 1'b0);
        chk("vfy_bad_busy", {prg_mode, done, error}, {1'b1, 1'b0, 1'b0});
        cyc(1'b0, 8'h00, 1'b0);
        chk("vfy_bad", {prg_mode, done, error}, {1'b1, 1'b0, 1'b1});
        wait_idle("vfy_bad_idle");
        corrupt = 1'b0;

        // Zero-length frame verifies immediately.
        send_hdr(32'h40, 16'd0);
        send(8'h00);
        cyc(1'b0, 8'h00, 1'b0);
        chk("vfy_n0", {prg_mode, done, error}, {1'b1, 1'b1, 1'b0});
        wait_idle("vfy_n0_idle");

        // Reset during VERIFY.
        send_hdr(32'h40, 16'd2);
        send_word(32'hDEADBEEF);
        send_word(32'h01020304);
        send(8'h42);
        repeat (2) cyc(1'b0, 8'h00, 1'b0);
        reset = 1'b1;
        cyc(1'b0, 8'h00, 1'b0);
        reset = 1'b0;
        all_zero("vfy_reset");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
